serial_mag_cmp: RTL
===================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; latched with operands.
REQ-006 SHALL have port a  input  WIDTH  first operand; latched on accepted start.
REQ-007 SHALL have port b  input  WIDTH  second operand; latched on accepted start.
REQ-008 SHALL have port ready  output  1  high exactly when the FSM is in IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port gt  output  1  a > b for the last completed compare.
REQ-011 SHALL have port eq  output  1  a == b for the last completed compare.
REQ-012 SHALL have port lt  output  1  a < b for the last completed compare.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL latch a, b and signed_mode, set bit index to WIDTH-1, and go to RUN; start=0 SHALL stay in IDLE.
REQ-015 RUN: each cycle SHALL compare exactly one bit pair at the current index, MSB first.
REQ-016 RUN: if the bits differ, the FSM SHALL register the result and go to DONE.
REQ-017 Unsigned mode, or signed mode with index < WIDTH-1: a bit 1 SHALL give gt=1; a bit 0 SHALL give lt=1.
REQ-018 Signed mode with index == WIDTH-1: a bit 1 SHALL give lt=1; a bit 0 SHALL give gt=1 (sign inversion).
REQ-019 RUN: if the bits are equal and index == 0, the FSM SHALL set eq=1 and go to DONE; otherwise it SHALL decrement index and stay in RUN.
REQ-020 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-021 Latency: with start accepted in cycle 0 and first differing bit at position p, done SHALL be high in cycle WIDTH-p+1.
REQ-022 Latency for equal operands SHALL be WIDTH+1 cycles; minimum latency (MSB differs) SHALL be 2 cycles.
REQ-023 Exactly one of gt/eq/lt SHALL be 1 after the first completed compare.
REQ-024 gt/eq/lt SHALL hold their value until the next compare's DONE cycle; they SHALL NOT change during RUN.
REQ-025 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-026 Changes on a, b or signed_mode after acceptance SHALL NOT affect the running compare.
REQ-027 Back-to-back operation: start held high SHALL be accepted in the first IDLE cycle after DONE, giving a throughput of one compare per latency+1 cycles.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, ready=1, done=0, gt=0, eq=0, lt=0, and clear the operand registers and index, regardless of clock.
REQ-029 Reset asserted during RUN or DONE SHALL abort the compare with no done pulse; the first start after reset release SHALL be handled normally.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, DONE) and the constants for WIDTH default and legal range.
REQ-031 One sub-module, bit_cmp, SHALL be used: a combinational 1-bit compare taking (a_bit, b_bit, invert) and returning (gt, lt), instanced once.
REQ-032 The index register SHALL be $clog2(WIDTH) bits wide; no multiply or full-width subtractor SHALL be inferred.

Verification
REQ-033 WIDTH=2, unsigned, all 16 (a,b) pairs: gt matches a>b exactly for every pair (e.g. 10 vs 01 -> gt=1); each done arrives within 3 cycles.
REQ-034 WIDTH=8, unsigned, a=8'hA5, b=8'hA5 -> eq=1, done in cycle 9; a=8'h80, b=8'h7F -> gt=1, done in cycle 2.
REQ-035 WIDTH=8, signed, a=8'h80 (-128), b=8'h7F (127) -> lt=1, done in cycle 2; a=8'hFF, b=8'hFE -> gt=1, done in cycle 9.
REQ-036 Start re-asserted during RUN, with a/b changed mid-run -> ignored, and the result reflects the originally latched operands.
REQ-037 reset_n pulsed low at RUN cycle 3 of an equal-operand compare -> no done pulse, outputs 0, ready=1; next start completes correctly.
REQ-038 start held high for 3 compares -> exactly 3 done pulses, each followed by exactly one ready cycle.

Source files
------------

// File: rtl/serial_mag_cmp_pkg.sv
// rtl/serial_mag_cmp_pkg.sv - shared FSM states and width limits for the serial magnitude comparator
package serial_mag_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 64;

endpackage

// File: rtl/serial_mag_cmp_bit_cmp.sv
// rtl/serial_mag_cmp_bit_cmp.sv - combinational single-bit magnitude compare
module bit_cmp (
  input  logic a_bit,
  input  logic b_bit,
  input  logic invert,
  output logic gt,
  output logic lt
);

  // invert swaps the sense of the sign bit in two's-complement compares
  assign gt = invert ? (~a_bit &  b_bit) : ( a_bit & ~b_bit);
  assign lt = invert ? ( a_bit & ~b_bit) : (~a_bit &  b_bit);

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - MSB-first bit-serial signed/unsigned magnitude comparator
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IDX_W-1:0] idx;
  logic             bit_gt;
  logic             bit_lt;
  logic             differ;
  logic             at_msb;
  logic             at_lsb;

  assign at_msb = (idx == IDX_MSB);
  assign at_lsb = (idx == '0);
  assign differ = bit_gt | bit_lt;

  bit_cmp u_bit_cmp (
    .a_bit  (a_q[idx]),
    .b_bit  (b_q[idx]),
    .invert (signed_q & at_msb),
    .gt     (bit_gt),
    .lt     (bit_lt)
  );

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (differ || at_lsb) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Result flags only move on the RUN->DONE transition so they stay stable between compares
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx      <= IDX_MSB;
          end
        end
        ST_RUN: begin
          if (differ) begin
            gt <= bit_gt;
            lt <= bit_lt;
            eq <= 1'b0;
          end else if (at_lsb) begin
            gt <= 1'b0;
            lt <= 1'b0;
            eq <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
